regfile_port_arbiter: RTL and testbench
=======================================

# regfile_port_arbiter

Round-robin arbiter that shares the single read/write port pair of the 16x8 register file between two requesters, for example two FSM datapaths like the min/sum scanner. It accepts one transaction at a time, drives the register file's address, enable and write-data inputs, and returns read data to the granted requester with a one-cycle valid pulse. It sits between the requesting controllers and the register file instance, and is the only block that drives the file's enables.

## Interface
- ADDR_W, 4, register-file address width (16 entries)
- DATA_W, 8, register-file data width
- Clk  in  1  rising-edge clock
- Rst_n  in  1  reset, synchronous, active-low
- req0 / req1  in  1  transaction request; held with we/addr/wdata stable until the matching gnt
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  target entry
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted and issued to the file this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata valid
- rdata0 / rdata1  out  DATA_W  read result; holds the last value until the next read for that requester
- rf_raddr / rf_waddr  out  ADDR_W  file read/write address (both carry the granted addr)
- rf_ren / rf_wen  out  1  file read/write enable
- rf_wdata  out  DATA_W  file write data
- rf_rdata  in  DATA_W  file read data; valid the cycle after rf_ren
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, RWAIT, RDONE. All outputs are registered.
- IDLE: if any req is high, choose the winner, latch its we/addr/wdata and id, then go to ISSUE. Otherwise stay in IDLE.
- Winner selection:
  - Only one req high: that requester wins.
  - Both high: the requester not granted last wins.
  - The last-granted pointer updates on every grant and resets to 1, so requester 0 wins the first tie.
- ISSUE: pulse gnt of the winner. Drive rf_raddr = rf_waddr = latched addr.
  - Write: rf_wen=1, rf_wdata = latched wdata, next state IDLE.
  - Read: rf_ren=1, next state RWAIT.
- RWAIT: capture rf_rdata into the winner's rdata register, then go to RDONE.
- RDONE: pulse rvalid of the winner, then go to IDLE.
- rf_ren, rf_wen and gnt are high only in ISSUE. Never assert both enables in the same cycle.
- Requesters drop req in the cycle after gnt. A req still high when the FSM returns to IDLE is treated as a new request.
- Non-granted requests wait, with no timeout. Round-robin fairness bounds the wait to one transaction of the other requester.
- The latched operands are immune to input changes after the IDLE sample.
- Reset (Rst_n=0 at an edge), including mid-transaction:
  - State goes to IDLE and the pointer to 1.
  - gnt*, rvalid*, rf_ren, rf_wen and busy go to 0.
  - rdata*, rf_wdata and rf_*addr go to 0.
  - An in-flight read produces no rvalid.

## Timing
- Cycle N: IDLE samples req.
- Cycle N+1: ISSUE (gnt, enable, address).
- Writes: the file updates at the edge ending N+1, and IDLE is back at N+2. Throughput is 1 write per 2 cycles.
- Reads: RWAIT at N+2, rvalid and rdata at N+3, IDLE at N+4. Request-to-data latency is 3 cycles; throughput is 1 read per 4 cycles.
- Back-to-back requests from the same requester get no bubble beyond the above. Grant order alternates under continuous contention.
- A write to address A followed by a read of A (either requester) returns the new value.

## Test plan
- Reset: hold Rst_n=0 for 2 cycles with req0=req1=1 -> all outputs 0, busy=0, no gnt. Release -> gnt0 pulses 2 cycles later.
- Single write/read: req0 writes addr 5 with 0xA7, then req0 reads addr 5 -> gnt0 at N+1, rf_wen=1 with rf_waddr=5. The read gives rvalid0 with rdata0=0xA7 exactly 3 cycles after the read request is sampled; rvalid1 stays 0.
- Contention: req0 and req1 both held high for 6 transactions (all reads of different addresses) -> grants alternate 0,1,0,1,0,1. Each rdata matches its preloaded file content.
- Write/read crossing: req1 writes 0xFF to addr 15 while req0 waits to read addr 15 -> req1 is granted first (pointer), and req0 receives 0xFF.
- Reset mid-read: assert Rst_n=0 during RWAIT -> no rvalid pulse, rdata0=0 and state IDLE on the next cycle; the next read completes normally.
- Enable exclusivity: random req/we/addr traffic for 1000 cycles -> rf_ren and rf_wen are never high together, exactly one gnt per ISSUE cycle, and the rvalid count equals the read-grant count.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
// Shares the single read/write port pair of the 16x8 register file between two
// requesters. One transaction is accepted at a time. On a tie, the requester
// that was not granted last wins. Every output comes straight from a flop.
//
// Ports:
//   Clk, Rst_n               clock, synchronous active-low reset
//   req*/we*/addr*/wdata*    per-requester transaction request and operands
//   gnt*                     one-cycle pulse when the request is issued to the file
//   rvalid*/rdata*           one-cycle read-valid pulse and held read result
//   rf_raddr/rf_waddr        file addresses (both carry the granted address)
//   rf_ren/rf_wen/rf_wdata   file enables and write data
//   rf_rdata                 file read data, valid the cycle after rf_ren
//   busy                     high whenever a transaction is in flight
module regfile_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rf_raddr,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic              rf_ren,
  output logic              rf_wen,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, RDONE} state_t;

  state_t            state, state_nxt;
  logic              last_gnt, last_gnt_nxt;
  logic              win;
  logic              op_we, op_we_nxt;
  logic              op_id, op_id_nxt;
  logic [ADDR_W-1:0] op_addr, op_addr_nxt;
  logic [DATA_W-1:0] op_wdata, op_wdata_nxt;
  logic              gnt0_nxt, gnt1_nxt;
  logic              rvalid0_nxt, rvalid1_nxt;
  logic              rf_ren_nxt, rf_wen_nxt;

  // The latched operands drive the file directly. They only change at the IDLE
  // sample, so they stay stable for the whole transaction whatever the
  // requesters do with their inputs afterwards.
  assign rf_raddr = op_addr;
  assign rf_waddr = op_addr;
  assign rf_wdata = op_wdata;

  // Next-state and next-output logic. The pulse outputs are computed one cycle
  // early so that their flops are high in ISSUE (gnt, enables) and in RDONE
  // (rvalid).
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    op_we_nxt    = op_we;
    op_id_nxt    = op_id;
    op_addr_nxt  = op_addr;
    op_wdata_nxt = op_wdata;
    gnt0_nxt     = 1'b0;
    gnt1_nxt     = 1'b0;
    rvalid0_nxt  = 1'b0;
    rvalid1_nxt  = 1'b0;
    rf_ren_nxt   = 1'b0;
    rf_wen_nxt   = 1'b0;
    // On a tie the requester that was not granted last wins. Otherwise the
    // single active requester wins.
    win          = (req0 && req1) ? ~last_gnt : req1;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt    = ISSUE;
          last_gnt_nxt = win;
          op_id_nxt    = win;
          op_we_nxt    = win ? we1 : we0;
          op_addr_nxt  = win ? addr1 : addr0;
          op_wdata_nxt = win ? wdata1 : wdata0;
          gnt0_nxt     = ~win;
          gnt1_nxt     = win;
          rf_wen_nxt   = op_we_nxt;
          rf_ren_nxt   = ~op_we_nxt;
        end
      end
      ISSUE: begin
        state_nxt = op_we ? IDLE : RWAIT;
      end
      RWAIT: begin
        state_nxt   = RDONE;
        rvalid0_nxt = ~op_id;
        rvalid1_nxt = op_id;
      end
      RDONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, operand and output registers. A reset aborts any transaction in
  // flight. Because the rvalid flop is cleared here, an interrupted read never
  // produces its pulse.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      op_we    <= 1'b0;
      op_id    <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rf_ren   <= 1'b0;
      rf_wen   <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      op_we    <= op_we_nxt;
      op_id    <= op_id_nxt;
      op_addr  <= op_addr_nxt;
      op_wdata <= op_wdata_nxt;
      gnt0     <= gnt0_nxt;
      gnt1     <= gnt1_nxt;
      rvalid0  <= rvalid0_nxt;
      rvalid1  <= rvalid1_nxt;
      rf_ren   <= rf_ren_nxt;
      rf_wen   <= rf_wen_nxt;
      busy     <= (state_nxt != IDLE);
      // The file returns read data during RWAIT. Capture it for the winner only.
      if (state == RWAIT) begin
        if (op_id) rdata1 <= rf_rdata;
        else       rdata0 <= rf_rdata;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter
// Directed and random traffic from two requester agents. A small register-file
// model is attached to the rf_* port. Expected behaviour comes from a
// transaction-level model: when the arbiter becomes free, who wins a tie, what
// a read must return, and when each pulse must appear.
module tb_regfile_port_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
  } cmd_t;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] rf_raddr, rf_waddr;
  logic              rf_ren, rf_wen, busy;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;

  always #5 Clk = ~Clk;

  regfile_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .rf_raddr(rf_raddr), .rf_waddr(rf_waddr), .rf_ren(rf_ren), .rf_wen(rf_wen),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .busy(busy)
  );

  // Register-file model: synchronous write, registered read. It is preloaded
  // with i*13+7 on the first clock edge.
  logic [7:0] mem [16];
  bit         preloaded = 1'b0;
  always @(posedge Clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 13 + 7);
      preloaded <= 1'b1;
    end else if (rf_wen) begin
      mem[rf_waddr] <= rf_wdata;
    end
    if (rf_ren) rf_rdata <= mem[rf_raddr];
  end

  // Scoreboard counters.
  int n_asserts = 0;
  int n_fail = 0;

  // Requester agents.
  cmd_t q0[$], q1[$];
  bit   pend [2];
  cmd_t cur [2];
  bit   saw_g [2];
  bit   rand_mode = 1'b0;

  // Reference model state.
  int         cyc = 0;
  int         idle_from = 0;
  bit         last = 1'b1;
  bit         armed = 1'b0;
  bit         rst_prev = 1'b0;
  bit         prev_req [2];
  cmd_t       prev_cmd [2];
  logic [7:0] shadow [16];
  bit         rd_pend = 1'b0;
  bit         rd_id = 1'b0;
  logic [7:0] rd_data = '0;
  int         rd_due = 0;
  logic [7:0] exp_rdata [2];
  int         exp_reads = 0;
  int         rv_act = 0;
  bit         rec_order = 1'b0;
  bit         order_q[$];

  function automatic cmd_t mk(input logic we, input logic [3:0] a, input logic [7:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.data = d;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    return mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Called once per cycle, at the falling edge. Advances the reference model
  // and compares every output against it.
  task automatic checkOutput();
    bit   eg [2];
    bit   er [2];
    bit   w;
    bit   granted;
    cmd_t c;
    eg[0] = 1'b0; eg[1] = 1'b0;
    granted = 1'b0;
    c = '0;
    if (rst_prev) begin
      idle_from = cyc;
      last = 1'b1;
      rd_pend = 1'b0;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      armed = 1'b1;
    end
    if (armed) begin
      if ((cyc - 1 >= idle_from) && (prev_req[0] || prev_req[1])) begin
        w = (prev_req[0] && prev_req[1]) ? !last : prev_req[1];
        c = prev_cmd[w];
        eg[w] = 1'b1;
        granted = 1'b1;
        last = w;
        if (c.we) begin
          shadow[c.addr] = c.data;
          idle_from = cyc + 1;
        end else begin
          rd_pend = 1'b1;
          rd_id = w;
          rd_data = shadow[c.addr];
          rd_due = cyc + 2;
          idle_from = cyc + 3;
          exp_reads++;
        end
      end
      er[0] = rd_pend && (rd_due == cyc) && (rd_id == 1'b0);
      er[1] = rd_pend && (rd_due == cyc) && (rd_id == 1'b1);
      if (rd_pend && rd_due == cyc) begin
        exp_rdata[rd_id] = rd_data;
        rd_pend = 1'b0;
      end
      checkVal("gnt0", gnt0, eg[0]);
      checkVal("gnt1", gnt1, eg[1]);
      checkVal("rf_ren", rf_ren, granted && !c.we);
      checkVal("rf_wen", rf_wen, granted && c.we);
      checkVal("rf_excl", rf_ren & rf_wen, 0);
      if (granted) begin
        checkVal("rf_raddr", rf_raddr, c.addr);
        checkVal("rf_waddr", rf_waddr, c.addr);
        if (c.we) checkVal("rf_wdata", rf_wdata, c.data);
      end
      if (rst_prev) begin
        checkVal("rst_raddr", rf_raddr, 0);
        checkVal("rst_waddr", rf_waddr, 0);
        checkVal("rst_wdata", rf_wdata, 0);
      end
      checkVal("rvalid0", rvalid0, er[0]);
      checkVal("rvalid1", rvalid1, er[1]);
      checkVal("rdata0", rdata0, exp_rdata[0]);
      checkVal("rdata1", rdata1, exp_rdata[1]);
      checkVal("busy", busy, cyc < idle_from);
      rv_act += int'(rvalid0) + int'(rvalid1);
      if (rec_order && gnt0) order_q.push_back(1'b0);
      if (rec_order && gnt1) order_q.push_back(1'b1);
    end
    saw_g[0] = (gnt0 === 1'b1);
    saw_g[1] = (gnt1 === 1'b1);
  endtask

  // One clock of stimulus: check outputs, let the agents react to grants, then
  // drive the inputs (and reset) that the next rising edge samples.
  task automatic applyStimulus(input bit do_reset);
    bit dropped;
    @(negedge Clk);
    cyc++;
    checkOutput();
    for (int i = 0; i < 2; i++) begin
      dropped = 1'b0;
      if (pend[i] && saw_g[i]) begin
        pend[i] = 1'b0;
        dropped = 1'b1;
      end
      if (!pend[i] && !dropped) begin
        if (i == 0 && q0.size() > 0) begin
          cur[0] = q0.pop_front(); pend[0] = 1'b1;
        end else if (i == 1 && q1.size() > 0) begin
          cur[1] = q1.pop_front(); pend[1] = 1'b1;
        end else begin
          cur[i] = rnd_cmd();
          if (rand_mode && $urandom_range(0, 2) == 0) pend[i] = 1'b1;
        end
      end else if (!pend[i]) begin
        cur[i] = rnd_cmd();
      end
    end
    req0 = pend[0]; we0 = cur[0].we; addr0 = cur[0].addr; wdata0 = cur[0].data;
    req1 = pend[1]; we1 = cur[1].we; addr1 = cur[1].addr; wdata1 = cur[1].data;
    prev_req[0] = pend[0]; prev_req[1] = pend[1];
    prev_cmd[0] = cur[0]; prev_cmd[1] = cur[1];
    Rst_n = !do_reset;
    rst_prev = do_reset;
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n = 0;
    do begin
      applyStimulus(1'b0);
      n++;
    end while ((pend[0] || pend[1] || q0.size() > 0 || q1.size() > 0 || rd_pend || cyc < idle_from) && n < budget);
    if (pend[0] || pend[1] || q0.size() > 0 || q1.size() > 0 || rd_pend || cyc < idle_from) begin
      n_asserts++;
      n_fail++;
      $error("[TB] FAIL %s_timeout observed=busy expected=idle within %0d cycles", tag, budget);
    end
  endtask

  initial begin
    bit first;
    int n;
    for (int i = 0; i < 16; i++) shadow[i] = 8'(i * 13 + 7);
    pend[0] = 1'b0; pend[1] = 1'b0;
    cur[0] = '0; cur[1] = '0;
    prev_req[0] = 1'b0; prev_req[1] = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;

    // Reset held for two edges with both requesters already asking. Nothing may
    // be granted until after release, and then requester 0 wins the tie.
    $display("[TB] reset with pending requests");
    q0.push_back(mk(1'b0, 4'd1, 8'h00));
    q1.push_back(mk(1'b0, 4'd2, 8'h00));
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    rec_order = 1'b1;
    order_q.delete();
    waitIdle(40, "t1");
    rec_order = 1'b0;
    checkVal("t1_first_gnt", order_q.size() > 0 ? order_q[0] : 1'bx, 0);

    // Single write then read-back by requester 0.
    $display("[TB] single write/read");
    q0.push_back(mk(1'b1, 4'd5, 8'hA7));
    waitIdle(20, "t2w");
    q0.push_back(mk(1'b0, 4'd5, 8'h00));
    waitIdle(20, "t2r");
    checkVal("t2_rdata0", rdata0, 8'hA7);

    // Continuous contention: six reads, and the grants must alternate.
    $display("[TB] contention");
    first = !last;
    for (int k = 0; k < 3; k++) begin
      q0.push_back(mk(1'b0, 4'(6 + 2 * k), 8'h00));
      q1.push_back(mk(1'b0, 4'(7 + 2 * k), 8'h00));
    end
    order_q.delete();
    rec_order = 1'b1;
    waitIdle(100, "t3");
    rec_order = 1'b0;
    checkVal("t3_ngrants", order_q.size(), 6);
    for (int k = 0; k < order_q.size(); k++) checkVal("t3_order", order_q[k], first ^ 1'(k));

    // Write/read crossing on address 15. Requester 0 was granted last, so the
    // write from requester 1 goes first and the read must see it.
    $display("[TB] write/read crossing");
    q0.push_back(mk(1'b0, 4'd0, 8'h00));
    waitIdle(20, "t4a");
    q1.push_back(mk(1'b1, 4'd15, 8'hFF));
    q0.push_back(mk(1'b0, 4'd15, 8'h00));
    order_q.delete();
    rec_order = 1'b1;
    waitIdle(40, "t4");
    rec_order = 1'b0;
    checkVal("t4_first_gnt", order_q.size() > 0 ? order_q[0] : 1'bx, 1);
    checkVal("t4_rdata0", rdata0, 8'hFF);

    // Reset during RWAIT: the read is abandoned and rdata0 clears.
    $display("[TB] reset mid-read");
    q0.push_back(mk(1'b0, 4'd3, 8'h00));
    n = 0;
    do begin
      applyStimulus(1'b0);
      n++;
    end while (!saw_g[0] && n < 20);
    checkVal("t5_gnt_seen", saw_g[0], 1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkVal("t5_rdata0_cleared", rdata0, 8'h00);
    checkVal("t5_busy", busy, 0);
    q0.push_back(mk(1'b0, 4'd3, 8'h00));
    waitIdle(20, "t5");
    checkVal("t5_rdata0", rdata0, 8'h2E);

    // Random traffic from both requesters.
    $display("[TB] random traffic");
    exp_reads = 0;
    rv_act = 0;
    rand_mode = 1'b1;
    repeat (1000) applyStimulus(1'b0);
    rand_mode = 1'b0;
    waitIdle(50, "t6");
    checkVal("t6_rvalid_count", rv_act, exp_reads);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
